// File: rtl/rob_if.sv
// Reorder-buffer port bundle: dispatch, CDB, operand lookup and commit channels.
// Dispatch is accepted on a cycle where disp_valid and disp_ready are both high; commit_valid is a pure strobe with no back-pressure.
interface rob_if #(parameter int DATA_W = 32);
    logic              flush;
    logic              disp_valid;
    logic [4:0]        disp_rd;
    logic              disp_regwrite;
    logic              disp_ready;
    logic [4:0]        disp_tag;
    logic              cdb_valid;
    logic [4:0]        cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic [4:0]        rs_tag;
    logic [4:0]        rt_tag;
    logic              rs_ready;
    logic              rt_ready;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              commit_valid;
    logic [4:0]        commit_tag;
    logic [4:0]        commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              commit_regwrite;
    logic [5:0]        dbg_count;

    modport master (
        output flush, disp_valid, disp_rd, disp_regwrite, cdb_valid, cdb_tag, cdb_data,
               rs_tag, rt_tag,
        input  disp_ready, disp_tag, rs_ready, rt_ready, rs_data, rt_data,
               commit_valid, commit_tag, commit_rd, commit_data, commit_regwrite, dbg_count
    );

    modport slave (
        input  flush, disp_valid, disp_rd, disp_regwrite, cdb_valid, cdb_tag, cdb_data,
               rs_tag, rt_tag,
        output disp_ready, disp_tag, rs_ready, rt_ready, rs_data, rt_data,
               commit_valid, commit_tag, commit_rd, commit_data, commit_regwrite, dbg_count
    );
endinterface

// File: rtl/rob.sv
// 32-entry reorder buffer: allocates tags at dispatch, collects CDB results,
// retires in program order and serves operand lookups from registered state.
module rob #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input logic  clock,
    input logic  reset,
    rob_if.slave bus
);
    localparam int TW = 5;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  regwrite_q;
    logic [TW-1:0]     rd_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TW-1:0]     head_q, head_d;
    logic [TW-1:0]     tail_q, tail_d;
    logic [TW:0]       count_q, count_d;

    logic clear;
    logic dispatch;
    logic cdb_hit;
    logic commit;

    assign clear    = reset | bus.flush;
    assign dispatch = bus.disp_valid & bus.disp_ready;
    assign cdb_hit  = bus.cdb_valid & valid_q[bus.cdb_tag];
    // Reset and flush both suppress the retirement that would otherwise happen this cycle.
    assign commit   = valid_q[head_q] & done_q[head_q] & ~clear;

    assign bus.disp_ready      = (count_q != (TW+1)'(DEPTH));
    assign bus.disp_tag        = tail_q;
    assign bus.commit_valid    = commit;
    assign bus.commit_tag      = head_q;
    assign bus.commit_rd       = rd_q[head_q];
    assign bus.commit_data     = data_q[head_q];
    assign bus.commit_regwrite = commit & regwrite_q[head_q];
    assign bus.rs_ready        = valid_q[bus.rs_tag] & done_q[bus.rs_tag];
    assign bus.rt_ready        = valid_q[bus.rt_tag] & done_q[bus.rt_tag];
    assign bus.rs_data         = data_q[bus.rs_tag];
    assign bus.rt_data         = data_q[bus.rt_tag];
    assign bus.dbg_count       = count_q;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_hit) begin
                done_d[bus.cdb_tag] = 1'b1;
            end
            // A full buffer never dispatches and an empty one never commits,
            // so the head and tail updates below cannot collide on one entry.
            if (commit) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            if (dispatch) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + 1'b1;
            end
            case ({dispatch, commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; valid/done gate every use of it.
    always_ff @(posedge clock) begin
        if (!clear) begin
            if (dispatch) begin
                rd_q[tail_q]       <= bus.disp_rd;
                regwrite_q[tail_q] <= bus.disp_regwrite;
            end
            if (cdb_hit) begin
                data_q[bus.cdb_tag] <= bus.cdb_data;
            end
        end
    end
endmodule

// File: doc/rob.md
# rob

32-entry reorder buffer for the out-of-order MIPS core and the tag producer for the register status table. At dispatch it allocates the 5-bit tag that the status table records against the destination register. It collects results broadcast on the common data bus (CDB) and retires entries strictly in program order. At each retirement it drives the committed tag and valid back to the status table and the result to the architectural register file. It also supplies operand values for two source tags looked up by the issue stage.

## Interface
- DEPTH, 32: number of entries; fixed at 32 because tags are 5 bits.
- DATA_W, 32: result width.

Ports, one per line: name, direction, width, meaning.

- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all entries, such as on a branch mispredict.
- disp_valid  in  1  dispatch request.
- disp_rd  in  5  destination register of the dispatched instruction.
- disp_regwrite  in  1  instruction writes a register.
- disp_ready  out  1  entry available.
- disp_tag  out  5  tag allocated to this dispatch; equals the tail pointer.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  5  tag of the broadcast result.
- cdb_data  in  32  broadcast result.
- rs_tag / rt_tag  in  5 each  operand tags to look up.
- rs_ready / rt_ready  out  1 each  looked-up entry is valid and done.
- rs_data / rt_data  out  32 each  value stored in the looked-up entry.
- commit_valid  out  1  head entry retires this cycle; goes to the status table's commit-valid input.
- commit_tag  out  5  tag of the retiring entry; goes to the status table's commit-tag input.
- commit_rd  out  5  destination register of the retiring entry.
- commit_data  out  32  result of the retiring entry.
- commit_regwrite  out  1  register-file write enable; equals commit_valid AND the entry's regwrite bit.

## Operation
- Per-entry state: valid, done, regwrite, rd[4:0], data[31:0].
- Pointers and counter: head[4:0], tail[4:0], count[5:0].
- Pointers wrap naturally from 31 to 0.
- disp_ready = (count != 32). It is computed from registered count only, with no credit for a same-cycle commit.
- Dispatch occurs when disp_valid and disp_ready are both high:
  - entry[tail] takes valid=1, done=0, rd, regwrite;
  - tail increments.
- A dispatch request while disp_ready is low is ignored, with no state change.
- CDB write occurs when cdb_valid is high and entry[cdb_tag].valid is set:
  - entry data takes cdb_data;
  - done is set to 1.
- A CDB write to an invalid entry is ignored.
- A repeated CDB write to a done entry overwrites its data.
- Commit is combinational from registered state: commit_valid = entry[head].valid AND entry[head].done AND NOT flush.
- On a commit edge, entry[head].valid clears and head increments.
- At most one commit per cycle.
- count update: +1 on dispatch only, −1 on commit only, unchanged when both occur in the same cycle.
- Lookups are combinational on registered state.
  - There is no CDB bypass: a result broadcast in cycle N is visible on rs_ready/rt_ready in cycle N+1.
- Flush has priority over dispatch, CDB and commit in the same cycle:
  - all valid and done bits clear;
  - head, tail and count go to 0;
  - commit_valid is forced low in that cycle.
- Reset has the same effect as flush.
  - Data, rd and regwrite are not reset.

## Timing
- Reset values:
  - disp_ready = 1, disp_tag = 0;
  - commit_valid = 0, commit_regwrite = 0;
  - rs_ready = rt_ready = 0.
  - commit_tag = 0, since it is driven from head.
  - commit_rd, commit_data, rs_data and rt_data are undefined until written.
- Dispatch at edge N: a CDB write for that tag is accepted from edge N+1.
- CDB write at edge N to the head entry: commit_valid is high in cycle N+1, so minimum dispatch-to-commit latency is 2 cycles.
- Steady-state throughput: 1 dispatch and 1 commit per cycle.
- The status table sees commit_tag/commit_valid in the same cycle as the register-file write.
- Reset or flush asserted mid-operation: the buffer is empty from the next cycle and no commit is issued in the asserting cycle.

## Test plan
- Fill and full: after reset, 32 consecutive dispatches with no CDB activity.
  - Required: disp_tag runs 0..31 and disp_ready drops low after the 32nd.
  - A 33rd request is ignored.
  - One CDB write to tag 0 → commit of tag 0 the next cycle, and disp_ready returns high.
- Out-of-order completion: dispatch tags 0, 1, 2, then CDB writes to 2 (0xC), 1 (0xB), 0 (0xA).
  - Required: no commit until tag 0 is done.
  - Then commits on three consecutive cycles: tag 0/0xA, tag 1/0xB, tag 2/0xC.
- Simultaneous dispatch and commit: with count = 5 and the head done, dispatch in the same cycle.
  - Required: count stays 5 and tail and head both advance.
  - With count = 32 and the head done, a same-cycle dispatch is refused.
- Wrap-around: 40 dispatch/complete/commit cycles.
  - Required: disp_tag wraps 31→0 and commit_tag follows in order with no loss.
  - commit_regwrite = 0 for entries dispatched with disp_regwrite = 0.
- Lookup: dispatch tag 3, look up rs_tag = 3.
  - Required: rs_ready = 0.
  - CDB write 0x1234 to tag 3 → rs_ready = 1 and rs_data = 0x1234 on the following cycle, not in the same cycle.
- Flush and reset mid-operation: 10 entries live and the head done, then flush in the same cycle as dispatch and CDB.
  - Required: commit_valid = 0 in that cycle.
  - Next cycle: disp_tag = 0, disp_ready = 1, no commits.
  - Repeat the same check using reset.
